// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit: load/store stage turning one memory op into a req/gnt/rvalid
// bus transaction plus an extended register write-back.
// Optional: define MEM_TIMEOUT_EN to abort stalled bus transactions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int REG_SEL_W   = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iMemOpDv,
  input  logic                 iRead,
  input  logic                 iWrite,
  input  logic [XLEN-1:0]      iAddr,
  input  logic [XLEN-1:0]      iData,
  input  logic [2:0]           iOpType,
  input  logic [REG_SEL_W-1:0] iRdAddr,
  output logic                 oBusy,
  output logic                 oRegDv,
  output logic [REG_SEL_W-1:0] oRegAddr,
  output logic [XLEN-1:0]      oRegData,
  output logic                 oExcept,
  output logic [1:0]           oExcCause,
  output logic                 oMemReq,
  output logic                 oMemWe,
  output logic [XLEN-1:0]      oMemAddr,
  output logic [XLEN-1:0]      oMemWData,
  output logic [XLEN/8-1:0]    oMemBe,
  input  logic                 iMemGnt,
  input  logic                 iMemRValid,
  input  logic [XLEN-1:0]      iMemRData
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]          mem_be_q, mem_be_d;
  logic                   reg_dv_q, reg_dv_d;
  logic [REG_SEL_W-1:0]   reg_addr_q, reg_addr_d;
  logic [XLEN-1:0]        reg_data_q, reg_data_d;
  logic                   except_q, except_d;
  logic [1:0]             exc_cause_q, exc_cause_d;
  logic [2:0]             ld_type_q, ld_type_d;
  logic [OFF_W-1:0]       ld_off_q, ld_off_d;
  logic [REG_SEL_W-1:0]   ld_rd_q, ld_rd_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic                   timer_expired;
  assign timer_expired = (timer_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  logic                   accept;
  logic                   op_legal;
  logic                   op_misaligned;
  logic [NB-1:0]          be_calc;
  logic [XLEN-1:0]        wdata_calc;
  logic [XLEN-1:0]        rdata_sh;
  logic                   ld_sign;
  logic [XLEN-1:0]        ld_ext;

  assign accept = iMemOpDv & (iRead ^ iWrite);

  // Doubleword and unsigned-word codes only exist on a 64-bit datapath.
  always_comb begin
    op_legal = 1'b0;
    if (iRead) begin
      case (iOpType)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
        3'b011, 3'b110:                         op_legal = (XLEN == 64);
        default:                                op_legal = 1'b0;
      endcase
    end else begin
      case (iOpType)
        3'b000, 3'b001, 3'b010: op_legal = 1'b1;
        3'b011:                 op_legal = (XLEN == 64);
        default:                op_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (iOpType[1:0])
      2'b01:   op_misaligned = iAddr[0];
      2'b10:   op_misaligned = (iAddr[1:0] != 2'b00);
      2'b11:   op_misaligned = (iAddr[2:0] != 3'b000);
      default: op_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      be_calc[i] = (i >= int'(iAddr[OFF_W-1:0])) &&
                   (i <  int'(iAddr[OFF_W-1:0]) + (1 << iOpType[1:0]));
    end
  end

  always_comb begin
    case (iOpType[1:0])
      2'b00:   wdata_calc = {NB{iData[7:0]}};
      2'b01:   wdata_calc = {(NB/2){iData[15:0]}};
      2'b10:   wdata_calc = {(NB/4){iData[31:0]}};
      default: wdata_calc = iData;
    endcase
  end

  assign rdata_sh = iMemRData >> {ld_off_q, 3'b000};

  always_comb begin
    case (ld_type_q[1:0])
      2'b00:   ld_sign = rdata_sh[7];
      2'b01:   ld_sign = rdata_sh[15];
      2'b10:   ld_sign = rdata_sh[31];
      default: ld_sign = rdata_sh[XLEN-1];
    endcase
    if (ld_type_q[2]) ld_sign = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      ld_ext[i] = (i < (8 << ld_type_q[1:0])) ? rdata_sh[i] : ld_sign;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    reg_dv_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    except_d    = 1'b0;
    exc_cause_d = 2'b00;
    ld_type_d   = ld_type_q;
    ld_off_d    = ld_off_q;
    ld_rd_d     = ld_rd_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!op_legal) begin
            except_d    = 1'b1;
            exc_cause_d = CAUSE_ILLEGAL;
          end else if (op_misaligned) begin
            except_d    = 1'b1;
            exc_cause_d = CAUSE_MISALIGN;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = iWrite;
            mem_addr_d  = {iAddr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d = wdata_calc;
            mem_be_d    = be_calc;
            ld_type_d   = iOpType;
            ld_off_d    = iAddr[OFF_W-1:0];
            ld_rd_d     = iRdAddr;
          end
        end
      end

      REQ: begin
        if (iMemGnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = IDLE;
          end else if (iMemRValid) begin
            state_d  = IDLE;
            reg_dv_d = (ld_rd_q != '0);
            if (ld_rd_q != '0) begin
              reg_addr_d = ld_rd_q;
              reg_data_d = ld_ext;
            end
          end else begin
            state_d = WAIT_R;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timer_expired) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          except_d    = 1'b1;
          exc_cause_d = CAUSE_TIMEOUT;
        end
`endif
      end

      WAIT_R: begin
        if (iMemRValid) begin
          state_d  = IDLE;
          reg_dv_d = (ld_rd_q != '0);
          if (ld_rd_q != '0) begin
            reg_addr_d = ld_rd_q;
            reg_data_d = ld_ext;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timer_expired) begin
          state_d     = IDLE;
          except_d    = 1'b1;
          exc_cause_d = CAUSE_TIMEOUT;
        end
`endif
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Restart the count on every state change so each wait phase gets a full budget.
  always_comb begin
    if (state_q == IDLE || state_d != state_q) timer_d = '0;
    else                                       timer_d = timer_q + 1'b1;
  end
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      reg_dv_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      except_q    <= 1'b0;
      exc_cause_q <= 2'b00;
      ld_type_q   <= 3'b000;
      ld_off_q    <= '0;
      ld_rd_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      reg_dv_q    <= reg_dv_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      except_q    <= except_d;
      exc_cause_q <= exc_cause_d;
      ld_type_q   <= ld_type_d;
      ld_off_q    <= ld_off_d;
      ld_rd_q     <= ld_rd_d;
`ifdef MEM_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign oBusy     = (state_q != IDLE);
  assign oRegDv    = reg_dv_q;
  assign oRegAddr  = reg_addr_q;
  assign oRegData  = reg_data_q;
  assign oExcept   = except_q;
  assign oExcCause = exc_cause_q;
  assign oMemReq   = mem_req_q;
  assign oMemWe    = mem_we_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oMemBe    = mem_be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32, TIMEOUT_CYC=8).
`default_nettype none

module tb_mem_access_unit;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iMemOpDv = 1'b0, iRead = 1'b0, iWrite = 1'b0;
  logic [31:0] iAddr = '0, iData = '0;
  logic [2:0]  iOpType = '0;
  logic [4:0]  iRdAddr = '0;
  logic        iMemGnt = 1'b0, iMemRValid = 1'b0;
  logic [31:0] iMemRData = '0;
  logic        oBusy, oRegDv, oExcept, oMemReq, oMemWe;
  logic [4:0]  oRegAddr;
  logic [31:0] oRegData, oMemAddr, oMemWData;
  logic [1:0]  oExcCause;
  logic [3:0]  oMemBe;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  mem_access_unit #(.XLEN(32), .REG_SEL_W(5), .TIMEOUT_CYC(8)) dut (
    .iClk(iClk), .iRst(iRst), .iMemOpDv(iMemOpDv), .iRead(iRead), .iWrite(iWrite),
    .iAddr(iAddr), .iData(iData), .iOpType(iOpType), .iRdAddr(iRdAddr),
    .oBusy(oBusy), .oRegDv(oRegDv), .oRegAddr(oRegAddr), .oRegData(oRegData),
    .oExcept(oExcept), .oExcCause(oExcCause), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemBe(oMemBe),
    .iMemGnt(iMemGnt), .iMemRValid(iMemRValid), .iMemRData(iMemRData)
  );

  // ---------------- reference model (RV32 rules) ----------------
  function automatic bit m_legal(input bit rd, input logic [2:0] t);
    if (rd) return (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
    return (t <= 3'd2);
  endfunction

  function automatic bit m_misal(input logic [2:0] t, input logic [31:0] a);
    int n = 1 << t[1:0];
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    int n = 1 << t[1:0];
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
    if (t[1:0] == 2'd0) return d[7:0] * 32'h0101_0101;
    if (t[1:0] == 2'd1) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v = rdata >> (8 * (a % 4));
    case (t)
      3'd0:    return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
      3'd1:    return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  // Present one op for exactly one edge; returns sampled just after that edge.
  task automatic issue(input bit rd, input bit wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    iMemOpDv = 1'b1; iRead = rd; iWrite = wr; iOpType = t; iAddr = a; iData = d; iRdAddr = r;
    @(posedge iClk); #1;
    iMemOpDv = 1'b0; iRead = 1'b0; iWrite = 1'b0;
  endtask

  task automatic step();
    @(posedge iClk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iRst = 1'b1; step(); step(); iRst = 1'b0;
    checks++;
    if ({oBusy, oRegDv, oExcept, oMemReq, oMemWe} !== 5'b0 || oRegAddr !== 5'd0 ||
        oRegData !== 32'd0 || oExcCause !== 2'd0 || oMemAddr !== 32'd0 ||
        oMemWData !== 32'd0 || oMemBe !== 4'd0) begin
      failures++;
      $display("FAIL reset: busy=%b dv=%b exc=%b req=%b we=%b addr=%h be=%h required all zero",
               oBusy, oRegDv, oExcept, oMemReq, oMemWe, oMemAddr, oMemBe);
    end
  endtask

  task automatic test_lb_sign();
    issue(1, 0, 3'b000, 32'h1003, 32'h0, 5'd5);
    checks++;
    if (oMemReq !== 1 || oMemWe !== 0 || oMemAddr !== 32'h1000 || oMemBe !== 4'b1000 || oBusy !== 1) begin
      failures++;
      $display("FAIL lb_req: req=%b we=%b addr=%h be=%b required 1 0 00001000 1000", oMemReq, oMemWe, oMemAddr, oMemBe);
    end
    iMemGnt = 1; step(); iMemGnt = 0;
    checks++;
    if (oMemReq !== 0 || oBusy !== 1 || oRegDv !== 0) begin
      failures++;
      $display("FAIL lb_wait: req=%b busy=%b dv=%b required 0 1 0", oMemReq, oBusy, oRegDv);
    end
    iMemRValid = 1; iMemRData = 32'h8012_3456; step(); iMemRValid = 0;
    checks++;
    if (oRegDv !== 1 || oRegAddr !== 5'd5 || oRegData !== 32'hFFFF_FF80 || oBusy !== 0) begin
      failures++;
      $display("FAIL lb_wb: dv=%b rd=%0d data=%h busy=%b required 1 5 ffffff80 0", oRegDv, oRegAddr, oRegData, oBusy);
    end
    step();
    checks++;
    if (oRegDv !== 0) begin
      failures++;
      $display("FAIL lb_pulse: dv=%b required 0", oRegDv);
    end
  endtask

  task automatic test_sh_store();
    issue(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 5'd9);
    checks++;
    if (oMemReq !== 1 || oMemWe !== 1 || oMemAddr !== 32'h2000 || oMemBe !== 4'b1100 || oMemWData !== 32'hBEEF_BEEF) begin
      failures++;
      $display("FAIL sh_req: req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00002000 1100 beefbeef",
               oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData);
    end
    iMemGnt = 1; step(); iMemGnt = 0;
    checks++;
    if (oBusy !== 0 || oMemReq !== 0 || oRegDv !== 0) begin
      failures++;
      $display("FAIL sh_done: busy=%b req=%b dv=%b required 0 0 0", oBusy, oMemReq, oRegDv);
    end
  endtask

  task automatic test_exceptions();
    issue(1, 0, 3'b010, 32'h3001, 32'h0, 5'd3);
    checks++;
    if (oExcept !== 1 || oExcCause !== 2'b01 || oMemReq !== 0 || oBusy !== 0) begin
      failures++;
      $display("FAIL misaligned: exc=%b cause=%b req=%b busy=%b required 1 01 0 0", oExcept, oExcCause, oMemReq, oBusy);
    end
    // Illegal code on a misaligned address: opType is checked first.
    issue(1, 0, 3'b011, 32'h3001, 32'h0, 5'd3);
    checks++;
    if (oExcept !== 1 || oExcCause !== 2'b10 || oMemReq !== 0) begin
      failures++;
      $display("FAIL illegal_ld: exc=%b cause=%b req=%b required 1 10 0", oExcept, oExcCause, oMemReq);
    end
    step();
    checks++;
    if (oExcept !== 0 || oMemReq !== 0 || oRegDv !== 0) begin
      failures++;
      $display("FAIL exc_pulse: exc=%b req=%b dv=%b required 0 0 0", oExcept, oMemReq, oRegDv);
    end
  endtask

  task automatic test_ignored();
    issue(1, 1, 3'b010, 32'h4000, 32'h0, 5'd1);
    checks++;
    if (oBusy !== 0 || oExcept !== 0 || oMemReq !== 0) begin
      failures++;
      $display("FAIL ignored_rw: busy=%b exc=%b req=%b required 0 0 0", oBusy, oExcept, oMemReq);
    end
    issue(0, 0, 3'b010, 32'h4000, 32'h0, 5'd1);
    checks++;
    if (oBusy !== 0 || oExcept !== 0 || oMemReq !== 0) begin
      failures++;
      $display("FAIL ignored_none: busy=%b exc=%b req=%b required 0 0 0", oBusy, oExcept, oMemReq);
    end
  endtask

  task automatic test_lhu_same_cycle();
    issue(1, 0, 3'b101, 32'h5000, 32'h0, 5'd12);
    iMemGnt = 1; iMemRValid = 1; iMemRData = 32'hABCD_1234; step();
    iMemGnt = 0; iMemRValid = 0;
    checks++;
    if (oRegDv !== 1 || oRegAddr !== 5'd12 || oRegData !== 32'h0000_1234 || oBusy !== 0 || oMemReq !== 0) begin
      failures++;
      $display("FAIL lhu_fast: dv=%b rd=%0d data=%h busy=%b required 1 12 00001234 0", oRegDv, oRegAddr, oRegData, oBusy);
    end
  endtask

  task automatic test_rd_zero_and_reset();
    logic seen_dv = 1'b0;
    issue(1, 0, 3'b010, 32'h6000, 32'h0, 5'd0);
    iMemGnt = 1; step(); iMemGnt = 0;
    iMemRValid = 1; iMemRData = 32'h1234_5678; step(); iMemRValid = 0;
    checks++;
    if (oRegDv !== 0 || oBusy !== 0) begin
      failures++;
      $display("FAIL rd_zero: dv=%b busy=%b required 0 0", oRegDv, oBusy);
    end
    issue(1, 0, 3'b010, 32'h7000, 32'h0, 5'd7);
    iMemGnt = 1; step(); iMemGnt = 0;
    iRst = 1; step(); iRst = 0;
    checks++;
    if (oBusy !== 0 || oMemReq !== 0) begin
      failures++;
      $display("FAIL rst_wait: busy=%b req=%b required 0 0", oBusy, oMemReq);
    end
    iMemRValid = 1; iMemRData = 32'hFFFF_FFFF; step(); iMemRValid = 0;
    seen_dv = oRegDv; step(); seen_dv |= oRegDv;
    checks++;
    if (seen_dv !== 0 || oBusy !== 0) begin
      failures++;
      $display("FAIL late_rvalid: dv=%b busy=%b required 0 0", seen_dv, oBusy);
    end
  endtask

  task automatic test_timeout();
    logic held = 1'b1;
    issue(0, 1, 3'b010, 32'h8000, 32'h1111_2222, 5'd0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin step(); held &= oMemReq; end
    checks++;
    if (held !== 1) begin
      failures++;
      $display("FAIL timeout_early: req_held=%b required 1", held);
    end
    step();
    checks++;
    if (oMemReq !== 0 || oExcept !== 1 || oExcCause !== 2'b11 || oBusy !== 0 || oRegDv !== 0) begin
      failures++;
      $display("FAIL timeout_abort: req=%b exc=%b cause=%b busy=%b required 0 1 11 0", oMemReq, oExcept, oExcCause, oBusy);
    end
`else
    for (int i = 0; i < 20; i++) begin step(); held &= oMemReq & oBusy & ~oExcept; end
    checks++;
    if (held !== 1) begin
      failures++;
      $display("FAIL no_timeout: req_held=%b required 1", held);
    end
    iMemGnt = 1; step(); iMemGnt = 0;
    checks++;
    if (oMemReq !== 0 || oBusy !== 0 || oExcept !== 0) begin
      failures++;
      $display("FAIL no_timeout_done: req=%b busy=%b exc=%b required 0 0 0", oMemReq, oBusy, oExcept);
    end
`endif
  endtask

  // Random back-to-back ops, random grant/rvalid latency, spurious rvalid before gnt.
  task automatic test_random_ops(input int n);
    for (int k = 0; k < n; k++) begin
      bit          rd   = 1'($urandom_range(0, 1));
      logic [2:0]  t    = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom;
      logic [31:0] d    = $urandom;
      logic [31:0] rdat = $urandom;
      logic [4:0]  r    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bit          same;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      issue(rd, !rd, t, a, d, r);
      if (!m_legal(rd, t)) begin
        checks++;
        if (oExcept !== 1 || oExcCause !== 2'b10 || oMemReq !== 0 || oBusy !== 0) begin
          failures++;
          $display("FAIL rnd_illegal k=%0d: exc=%b cause=%b req=%b required 1 10 0", k, oExcept, oExcCause, oMemReq);
        end
      end else if (m_misal(t, a)) begin
        checks++;
        if (oExcept !== 1 || oExcCause !== 2'b01 || oMemReq !== 0 || oBusy !== 0) begin
          failures++;
          $display("FAIL rnd_misal k=%0d: exc=%b cause=%b req=%b required 1 01 0", k, oExcept, oExcCause, oMemReq);
        end
      end else begin
        checks++;
        if (oMemReq !== 1 || oMemWe !== !rd || oMemAddr !== {a[31:2], 2'b00} || oMemBe !== m_be(t, a) ||
            (!rd && oMemWData !== m_wdata(t, d)) || oExcept !== 0) begin
          failures++;
          $display("FAIL rnd_req k=%0d t=%0d a=%h: req=%b we=%b addr=%h be=%b wd=%h required we=%b be=%b wd=%h",
                   k, t, a, oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData, !rd, m_be(t, a), m_wdata(t, d));
        end
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          iMemRValid = 1'($urandom_range(0, 1)); iMemRData = $urandom; step(); iMemRValid = 0;
          checks++;
          if (oMemReq !== 1 || oBusy !== 1 || oMemAddr !== {a[31:2], 2'b00} || oRegDv !== 0) begin
            failures++;
            $display("FAIL rnd_hold k=%0d: req=%b busy=%b addr=%h dv=%b required 1 1 %h 0", k, oMemReq, oBusy, oMemAddr, oRegDv, {a[31:2], 2'b00});
          end
        end
        same = rd && ($urandom_range(0, 1) != 0);
        iMemGnt = 1; iMemRValid = same; iMemRData = rdat; step(); iMemGnt = 0; iMemRValid = 0;
        if (rd && !same) begin
          checks++;
          if (oMemReq !== 0 || oBusy !== 1 || oRegDv !== 0) begin
            failures++;
            $display("FAIL rnd_wait k=%0d: req=%b busy=%b dv=%b required 0 1 0", k, oMemReq, oBusy, oRegDv);
          end
          repeat ($urandom_range(0, 3)) step();
          iMemRValid = 1; iMemRData = rdat; step(); iMemRValid = 0;
        end
        checks++;
        if (oBusy !== 0 || oMemReq !== 0 || oRegDv !== (rd && r != 0) ||
            (rd && r != 0 && (oRegAddr !== r || oRegData !== m_load(t, a, rdat)))) begin
          failures++;
          $display("FAIL rnd_done k=%0d t=%0d a=%h: busy=%b dv=%b rd=%0d data=%h required dv=%b rd=%0d data=%h",
                   k, t, a, oBusy, oRegDv, oRegAddr, oRegData, (rd && r != 0), r, m_load(t, a, rdat));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge iClk);
    test_reset();
    test_lb_sign();
    test_sh_store();
    test_exceptions();
    test_ignored();
    test_lhu_same_cycle();
    test_rd_zero_and_reset();
    test_timeout();
    test_random_ops(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store execution stage of the core; sits between ALU output (memory-op fields) and the data-memory bus.
- Converts one memory op into a req/gnt/rvalid bus transaction with byte enables, then returns a register write-back.
- Loads are sign/zero-extended; misaligned and illegal ops raise an exception pulse instead of a bus access.
- Generalises the 32-bit-only memory op to XLEN 32 or 64.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- REG_SEL_W, 5, destination-register address width.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- iClk  in  1  clock; single clock domain.
- iRst  in  1  reset; synchronous, active-high.
- iMemOpDv  in  1  memory op valid.
- iRead  in  1  load.
- iWrite  in  1  store.
- iAddr  in  XLEN  byte address.
- iData  in  XLEN  store data.
- iOpType  in  3  funct3 width code.
- iRdAddr  in  REG_SEL_W  load destination register.
- oBusy  out  1  stall upstream; high when state != IDLE.
- oRegDv  out  1  write-back valid, 1-cycle pulse.
- oRegAddr  out  REG_SEL_W  write-back register.
- oRegData  out  XLEN  extended load data.
- oExcept  out  1  exception pulse.
- oExcCause  out  2  01 misaligned, 10 illegal opType, 11 timeout.
- oMemReq  out  1  bus request.
- oMemWe  out  1  1 = write.
- oMemAddr  out  XLEN  aligned word address; low log2(XLEN/8) bits are 0.
- oMemWData  out  XLEN  lane-replicated store data.
- oMemBe  out  XLEN/8  byte enables.
- iMemGnt  in  1  request accepted.
- iMemRValid  in  1  read data valid.
- iMemRData  in  XLEN  read data.

Behaviour:
- Reset values: all outputs 0; state IDLE. A synchronous iRst from any state returns to IDLE at the next edge and drops oMemReq.
- FSM states: IDLE, REQ, WAIT_R.
- Acceptance in IDLE:
  - Accepted when iMemOpDv=1 and exactly one of iRead/iWrite is 1.
  - iRead=iWrite: op ignored, no exception.
  - Ops presented while busy are not sampled; upstream holds them.
- Width codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - LD, LWU and SD are legal only when XLEN=64. Every other code is illegal.
- Check order: illegal opType first, then alignment (H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0).
- On a failed check: oExcept=1 with the cause one cycle after acceptance; no bus access, no write-back; stay in IDLE.
- Legal op: IDLE -> REQ. oMemReq, oMemWe, oMemAddr, oMemWData and oMemBe are registered, valid the cycle after acceptance, and held stable until gnt.
- Byte enables and store data: BE = size mask shifted by the in-word offset. Store data is replicated across all lanes of its size (SB: byte in every lane).
- REQ with iMemGnt=1:
  - Store: go to IDLE; oMemReq drops next cycle.
  - Load: go to WAIT_R.
  - Load with iMemRValid also high in the same cycle: complete directly and return to IDLE.
- iMemRValid outside a pending load (IDLE, or REQ before gnt) is ignored.
- WAIT_R with iMemRValid=1:
  - Select the lane by the offset, sign- or zero-extend, go to IDLE.
  - oRegDv pulses the following cycle with oRegAddr=rd.
  - If rd=0 the bus read still occurs but oRegDv stays 0.
- Minimum latency: load accept T -> req T+1 -> gnt/rvalid T+1 -> oRegDv T+2.
- oBusy is combinational from state, so it is high the cycle after acceptance until return to IDLE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to REQ or WAIT_R and increments each cycle there.
  - On reaching TIMEOUT_CYC without gnt/rvalid: abort to IDLE, drop oMemReq, pulse oExcept with cause 11, no write-back.
- Not defined: no counter; REQ and WAIT_R wait indefinitely.

Test Plan:
- LB addr 0x1003, bus rdata 0x80xxxxxx, rd=5 -> oMemAddr 0x1000, BE 1000, oRegDv with data 0xFFFFFF80, addr 5.
- SH addr 0x2002, data 0x0000BEEF -> oMemWe=1, BE 1100, WData 0xBEEFBEEF, oBusy low 1 cycle after gnt, no oRegDv.
- LW addr 0x3001 -> oExcept=1, cause 01, oMemReq never asserted; XLEN=32 LD -> cause 10.
- LHU with gnt and rvalid in the same cycle, rdata 0xABCD1234, addr offset 0 -> oRegDv 0x00001234 two cycles after acceptance.
- Load with rd=0 -> bus read occurs, oRegDv stays 0; iRst in WAIT_R then a late rvalid -> IDLE, no oRegDv.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, gnt held low -> abort after 8 cycles, cause 11, oMemReq=0.
